// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART ASCII command frame collector and syntax checker
// Optional macro UART_CMD_LOWERCASE_EN: accept lowercase r/w commands and a-f hex, stored uppercased.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        DATA_EN,
   output logic        STATE_R_OUT,
   output logic        STATE_W_OUT,
   output logic [15:0] ADDR_OUT,
   output logic [63:0] DATA_OUT,
   output logic        FAIL_OUT,
   output logic        BUSY
);

   localparam logic [7:0]       CH_R      = 8'h52;
   localparam logic [7:0]       CH_W      = 8'h57;
   localparam logic [7:0]       CH_CR     = 8'h0D;
   localparam logic [7:0]       CH_LF     = 8'h0A;
   localparam logic [63:0]      READ_DATA = 64'h3030_3030_3030_3030;
   localparam bit               TO_EN     = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_TERM,
      S_FLUSH
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_is_wr;
   logic              w_is_wr_nxt;
   logic [2:0]        r_char_cnt;
   logic [2:0]        w_char_cnt_nxt;
   logic [15:0]       r_addr_sr;
   logic [15:0]       w_addr_sr_nxt;
   logic [63:0]       r_data_sr;
   logic [63:0]       w_data_sr_nxt;
   logic [CNT_W-1:0]  r_to_cnt;
   logic              r_data_en;
   logic              r_state_r;
   logic              r_state_w;
   logic              r_fail;
   logic [15:0]       r_addr_out;
   logic [63:0]       r_data_out;
   logic [7:0]        w_byte;
   logic              w_is_hex;
   logic              w_timeout;
   logic              w_ok;
   logic              w_fail;

   // Folding lowercase letters onto uppercase lets one set of uppercase rules cover both cases.
   always_comb begin
      w_byte = RX_DATA;
`ifdef UART_CMD_LOWERCASE_EN
      if (RX_DATA >= 8'h61 && RX_DATA <= 8'h7A) begin
         w_byte = RX_DATA & 8'hDF;
      end
`endif
   end

   assign w_is_hex  = (w_byte >= 8'h30 && w_byte <= 8'h39) ||
                      (w_byte >= 8'h41 && w_byte <= 8'h46);
   assign w_timeout = TO_EN && !RX_VALID && (r_state != S_IDLE) && (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt    = r_state;
      w_is_wr_nxt    = r_is_wr;
      w_char_cnt_nxt = r_char_cnt;
      w_addr_sr_nxt  = r_addr_sr;
      w_data_sr_nxt  = r_data_sr;
      w_ok           = 1'b0;
      w_fail         = 1'b0;
      if (RX_VALID) begin
         case (r_state)
            S_IDLE: begin
               if (w_byte == CH_R || w_byte == CH_W) begin
                  w_is_wr_nxt    = (w_byte == CH_W);
                  w_char_cnt_nxt = 3'd0;
                  w_state_nxt    = S_ADDR;
               end else if (RX_DATA != CH_CR && RX_DATA != CH_LF) begin
                  w_fail      = 1'b1;
                  w_state_nxt = S_FLUSH;
               end
            end
            S_ADDR: begin
               if (w_is_hex) begin
                  w_addr_sr_nxt = {r_addr_sr[7:0], w_byte};
                  if (r_char_cnt == 3'd1) begin
                     w_char_cnt_nxt = 3'd0;
                     w_state_nxt    = r_is_wr ? S_DATA : S_TERM;
                  end else begin
                     w_char_cnt_nxt = r_char_cnt + 3'd1;
                  end
               end else begin
                  w_fail      = 1'b1;
                  w_state_nxt = S_FLUSH;
               end
            end
            S_DATA: begin
               if (w_is_hex) begin
                  w_data_sr_nxt = {r_data_sr[55:0], w_byte};
                  if (r_char_cnt == 3'd7) begin
                     w_char_cnt_nxt = 3'd0;
                     w_state_nxt    = S_TERM;
                  end else begin
                     w_char_cnt_nxt = r_char_cnt + 3'd1;
                  end
               end else begin
                  w_fail      = 1'b1;
                  w_state_nxt = S_FLUSH;
               end
            end
            S_TERM: begin
               if (RX_DATA == CH_CR) begin
                  w_ok        = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_fail      = 1'b1;
                  w_state_nxt = S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (RX_DATA == CH_CR) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_timeout) begin
         // A stalled flush just gives up quietly; the failure was already reported.
         w_state_nxt = S_IDLE;
         w_fail      = (r_state != S_FLUSH);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_is_wr    <= 1'b0;
         r_char_cnt <= 3'd0;
         r_addr_sr  <= 16'h0;
         r_data_sr  <= 64'h0;
         r_to_cnt   <= '0;
         r_data_en  <= 1'b0;
         r_state_r  <= 1'b0;
         r_state_w  <= 1'b0;
         r_fail     <= 1'b0;
         r_addr_out <= 16'h0;
         r_data_out <= 64'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_is_wr    <= w_is_wr_nxt;
         r_char_cnt <= w_char_cnt_nxt;
         r_addr_sr  <= w_addr_sr_nxt;
         r_data_sr  <= w_data_sr_nxt;
         r_to_cnt   <= (RX_VALID || r_state == S_IDLE || w_timeout) ? '0 : r_to_cnt + CNT_ONE;
         r_data_en  <= w_ok | w_fail;
         if (w_ok) begin
            r_state_r  <= !r_is_wr;
            r_state_w  <= r_is_wr;
            r_fail     <= 1'b0;
            r_addr_out <= r_addr_sr;
            r_data_out <= r_is_wr ? r_data_sr : READ_DATA;
         end else if (w_fail) begin
            r_state_r <= 1'b0;
            r_state_w <= 1'b0;
            r_fail    <= 1'b1;
         end
      end
   end

   assign DATA_EN     = r_data_en;
   assign STATE_R_OUT = r_state_r;
   assign STATE_W_OUT = r_state_w;
   assign ADDR_OUT    = r_addr_out;
   assign DATA_OUT    = r_data_out;
   assign FAIL_OUT    = r_fail;
   assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser against a frame-level model
module tb_uart_cmd_parser;

   localparam int TO = 50;
   localparam int M_IDLE = 0, M_COLLECT = 1, M_FLUSH = 2;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  RX_DATA = 8'h00;
   logic        RX_VALID = 1'b0;
   logic        DATA_EN, STATE_R_OUT, STATE_W_OUT, FAIL_OUT, BUSY;
   logic [15:0] ADDR_OUT;
   logic [63:0] DATA_OUT;

   uart_cmd_parser #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .DATA_EN(DATA_EN), .STATE_R_OUT(STATE_R_OUT), .STATE_W_OUT(STATE_W_OUT),
      .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT), .FAIL_OUT(FAIL_OUT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       v;
      logic [7:0] b;
   } stim_t;
   stim_t q[$];

   // Reference model: tracks the text of the current frame and judges it by character position.
   int          m_mode, m_idle;
   logic [7:0]  m_buf[$];
   logic        m_en, m_r, m_w, m_fail;
   logic [15:0] m_addr;
   logic [63:0] m_data;

   function automatic logic [7:0] norm(input logic [7:0] b);
`ifdef UART_CMD_LOWERCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
      return b;
   endfunction

   function automatic bit is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
   endfunction

   function automatic logic [84:0] m_vec();
      return {m_en, (m_mode != M_IDLE), m_r, m_w, m_fail, m_addr, m_data};
   endfunction

   function automatic logic [84:0] dut_vec();
      return {DATA_EN, BUSY, STATE_R_OUT, STATE_W_OUT, FAIL_OUT, ADDR_OUT, DATA_OUT};
   endfunction

   task automatic m_reset();
      m_mode = M_IDLE; m_idle = 0; m_buf.delete();
      m_en = 0; m_r = 0; m_w = 0; m_fail = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic m_bad();
      m_en = 1; m_fail = 1; m_r = 0; m_w = 0; m_mode = M_FLUSH;
   endtask

   task automatic m_byte(input logic [7:0] raw);
      logic [7:0] c;
      int last;
      c = norm(raw);
      if (m_mode == M_IDLE) begin
         if (c == 8'h52 || c == 8'h57) begin
            m_buf.delete(); m_buf.push_back(c); m_mode = M_COLLECT;
         end else if (c != 8'h0D && c != 8'h0A) begin
            m_bad();
         end
      end else if (m_mode == M_COLLECT) begin
         last = (m_buf[0] == 8'h57) ? 11 : 3;
         if (m_buf.size() == last) begin
            if (c == 8'h0D) begin
               m_en = 1; m_fail = 0; m_w = (m_buf[0] == 8'h57); m_r = !m_w;
               m_addr = {m_buf[1], m_buf[2]};
               m_data = 64'h3030303030303030;
               if (m_w) for (int i = 3; i < 11; i++) m_data[8*(10-i) +: 8] = m_buf[i];
               m_mode = M_IDLE;
            end else begin
               m_bad();
            end
         end else if (is_hex(c)) begin
            m_buf.push_back(c);
         end else begin
            m_bad();
         end
      end else if (c == 8'h0D) begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic tick(input stim_t s);
      RX_VALID = s.v;
      RX_DATA  = s.v ? s.b : 8'($urandom);
      @(posedge CLK);
      m_en = 0;
      if (s.v) begin
         m_idle = 0;
         m_byte(s.b);
      end else if (m_mode != M_IDLE) begin
         m_idle++;
         if (m_idle == TO) begin
            if (m_mode == M_COLLECT) m_bad();
            m_mode = M_IDLE;
            m_idle = 0;
         end
      end
      #1;
      RX_VALID = 1'b0;
   endtask

   task automatic push_str(input string s, input int gap);
      stim_t e;
      for (int i = 0; i < s.len(); i++) begin
         e.v = 1'b1; e.b = s[i]; q.push_back(e);
         for (int k = 0; k < gap; k++) begin
            e.v = 1'b0; e.b = 8'h00; q.push_back(e);
         end
      end
   endtask

   task automatic push_idle(input int n);
      stim_t e;
      e.v = 1'b0; e.b = 8'h00;
      for (int k = 0; k < n; k++) q.push_back(e);
   endtask

   task automatic test_reset();
      RST_N = 1'b0; RX_VALID = 1'b1; RX_DATA = 8'h57;
      repeat (2) @(posedge CLK);
      m_reset();
      #1;
      RX_VALID = 1'b0; RST_N = 1'b1;
      checks++;
      if (dut_vec() !== 85'b0) begin
         errors++; $display("FAIL reset got %h exp 0", dut_vec());
      end
   endtask

   task automatic test_write();
      int n_en = 0, en_idx = -1;
      q.delete(); push_str("W1A0000BEEF\015", 15);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL write cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1) begin n_en++; if (en_idx < 0) en_idx = i; end
      end
      checks++;
      if (n_en !== 1 || en_idx !== 176) begin
         errors++; $display("FAIL write_strobe got n=%0d at %0d exp n=1 at 176", n_en, en_idx);
      end
      checks++;
      if ({STATE_W_OUT, STATE_R_OUT, FAIL_OUT, ADDR_OUT, DATA_OUT} !== {3'b100, 16'h3141, 64'h30303030_42454546}) begin
         errors++; $display("FAIL write_value got %h %h exp 3141 3030303042454546", ADDR_OUT, DATA_OUT);
      end
   endtask

   task automatic test_read();
      int n_en = 0, en_idx = -1;
      q.delete(); push_str("R7F\015", 0); push_idle(3);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL read cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1) begin n_en++; if (en_idx < 0) en_idx = i; end
      end
      checks++;
      if (n_en !== 1 || en_idx !== 3) begin
         errors++; $display("FAIL read_strobe got n=%0d at %0d exp n=1 at 3", n_en, en_idx);
      end
      checks++;
      if ({STATE_W_OUT, STATE_R_OUT, FAIL_OUT, ADDR_OUT, DATA_OUT} !== {3'b010, 16'h3746, 64'h3030303030303030}) begin
         errors++; $display("FAIL read_value got %h %h exp 3746 3030303030303030", ADDR_OUT, DATA_OUT);
      end
   endtask

   task automatic test_flush();
      int n_en = 0, first_fail = -1;
      q.delete(); push_str("W1G", 1); push_str("Z\015", 1); push_str("R00\015", 1);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL flush cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1) begin
            n_en++;
            if (first_fail < 0) first_fail = FAIL_OUT ? i : 1000;
         end
      end
      checks++;
      if (n_en !== 2 || first_fail !== 4) begin
         errors++; $display("FAIL flush_strobes got n=%0d fail_at=%0d exp n=2 fail_at=4", n_en, first_fail);
      end
      checks++;
      if ({STATE_R_OUT, FAIL_OUT, ADDR_OUT} !== {2'b10, 16'h3030}) begin
         errors++; $display("FAIL flush_read got r=%b f=%b a=%h exp r=1 f=0 a=3030", STATE_R_OUT, FAIL_OUT, ADDR_OUT);
      end
   endtask

   task automatic test_timeout();
      int n_en = 0, en_idx = -1;
      q.delete();
      push_str("W12", 0); push_idle(60); push_str("R12\015", 0); push_idle(2);
      push_str("X", 0); push_idle(60); push_str("R12\015", 0); push_idle(2);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL timeout cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1) begin n_en++; if (en_idx < 0) en_idx = i; end
      end
      checks++;
      if (n_en !== 4 || en_idx !== 52) begin
         errors++; $display("FAIL timeout_strobes got n=%0d first=%0d exp n=4 first=52", n_en, en_idx);
      end
   endtask

   task automatic test_reset_mid();
      q.delete(); push_str("W12345", 0);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL rstmid_pre cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
      end
      RST_N = 1'b0; RX_VALID = 1'b1; RX_DATA = 8'h36;
      @(posedge CLK);
      m_reset();
      #1;
      RX_VALID = 1'b0; RST_N = 1'b1;
      checks++;
      if (dut_vec() !== 85'b0) begin
         errors++; $display("FAIL rstmid_clear got %h exp 0", dut_vec());
      end
      q.delete(); push_str("R05\015", 0); push_idle(2);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL rstmid_post cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
      end
      checks++;
      if ({STATE_R_OUT, FAIL_OUT, ADDR_OUT} !== {2'b10, 16'h3035}) begin
         errors++; $display("FAIL rstmid_read got a=%h f=%b exp a=3035 f=0", ADDR_OUT, FAIL_OUT);
      end
   endtask

   task automatic test_lowercase();
      int first_fail = -1;
      q.delete(); push_str("w0a00000001\015", 2);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL lower cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1 && FAIL_OUT === 1'b1 && first_fail < 0) first_fail = i;
      end
      checks++;
`ifdef UART_CMD_LOWERCASE_EN
      if ({STATE_W_OUT, FAIL_OUT, ADDR_OUT, DATA_OUT} !== {2'b10, 16'h3041, 64'h30303030_30303031} || first_fail !== -1) begin
         errors++; $display("FAIL lower_accept got w=%b a=%h d=%h exp w=1 a=3041 d=3030303030303031", STATE_W_OUT, ADDR_OUT, DATA_OUT);
      end
`else
      if (first_fail !== 0) begin
         errors++; $display("FAIL lower_reject got fail_at=%0d exp 0", first_fail);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int n_en = 0;
      q.delete(); push_str("R01\015\012W2233445566\015R0A\015\015\012", 0); push_idle(2);
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL b2b cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
         if (DATA_EN === 1'b1) n_en++;
      end
      checks++;
      if (n_en !== 3 || FAIL_OUT !== 1'b0 || ADDR_OUT !== 16'h3041) begin
         errors++; $display("FAIL b2b_count got n=%0d a=%h exp n=3 a=3041", n_en, ADDR_OUT);
      end
   endtask

   task automatic test_random();
      string hexs;
      stim_t e;
      logic [7:0] fr[$];
      int len, gap;
      hexs = "0123456789ABCDEFabcdef";
      q.delete();
      for (int f = 0; f < 250; f++) begin
         fr.delete();
         case ($urandom_range(0, 3))
            0, 2: begin
               fr.push_back(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h57);
               len = (fr[0] == 8'h57) ? 10 : 2;
               for (int k = 0; k < len; k++) fr.push_back(hexs[$urandom_range(0, 15)]);
               fr.push_back(8'h0D);
               if ($urandom_range(0, 1) == 0) fr[$urandom_range(0, fr.size() - 1)] = 8'($urandom);
            end
            1: begin
               fr.push_back(($urandom_range(0, 1) == 0) ? 8'h72 : 8'h77);
               for (int k = 0; k < 10; k++) fr.push_back(hexs[$urandom_range(0, 21)]);
               fr.push_back(8'h0D);
            end
            default: begin
               len = $urandom_range(1, 6);
               for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
               fr.push_back(8'h0D);
            end
         endcase
         foreach (fr[k]) begin
            e.v = 1'b1; e.b = fr[k]; q.push_back(e);
            gap = ($urandom_range(0, 15) == 0) ? $urandom_range(47, 53) : $urandom_range(0, 2);
            push_idle(gap);
         end
      end
      for (int i = 0; i < q.size(); i++) begin
         tick(q[i]);
         checks++;
         if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL random cyc %0d got %h exp %h", i, dut_vec(), m_vec());
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_write();
      test_read();
      test_flush();
      test_timeout();
      test_reset_mid();
      test_lowercase();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Front-end stage of the UART register-access path. Sits between the UART byte receiver and the ASCII-hex decoder stage.
- Collects received bytes into one ASCII command frame, checks the frame syntax, and presents a raw ASCII address/data word with a one-cycle DATA_EN strobe.
- Output bus layout matches the decoder's inputs exactly: high-order character in the high byte.

Parameters:
- TIMEOUT_CYC, 1000000, max CLK cycles allowed between bytes inside a frame; 0 disables the timeout.
- CNT_W, 32, width of the timeout counter; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- CLK  in  1  system clock; all logic rises on posedge.
- RST_N  in  1  synchronous reset, active-low.
- RX_DATA  in  8  received byte; valid only while RX_VALID=1.
- RX_VALID  in  1  one-cycle strobe per received byte.
- DATA_EN  out  1  one-cycle strobe: frame result valid on the outputs below.
- STATE_R_OUT  out  1  frame was a read command.
- STATE_W_OUT  out  1  frame was a write command.
- ADDR_OUT  out  16  two ASCII address characters; first received char in [15:8].
- DATA_OUT  out  64  eight ASCII data characters; first received char in [63:56].
- FAIL_OUT  out  1  frame was malformed or timed out.
- BUSY  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset: one clock, synchronous and active-low. While RST_N=0 on a rising edge:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The shift registers and counters clear.
  - A frame in progress is discarded and produces no strobe.
- Frame formats:
  - Read: 'R'(0x52) A1 A0 CR(0x0D).
  - Write: 'W'(0x57) A1 A0 D7..D0 CR.
  - Hex chars are 0x30-0x39 and 0x41-0x46 only.
- FSM states: IDLE, ADDR, DATA, TERM, FLUSH. The state advances only on RX_VALID=1, except on timeout.
- IDLE:
  - 'R' or 'W': latch the command type, clear the char counter, go to ADDR.
  - CR (0x0D) or LF (0x0A): ignored, stay in IDLE.
  - Any other byte: fail strobe, go to FLUSH.
- ADDR:
  - Hex byte: shift into addr_sr (addr_sr <= {addr_sr[7:0], byte}). After 2 chars, go to DATA if write, TERM if read.
  - Non-hex byte: fail strobe, go to FLUSH.
- DATA:
  - Hex byte: shift into data_sr 8 bits at a time. After 8 chars, go to TERM.
  - Non-hex byte: fail strobe, go to FLUSH.
- TERM:
  - CR: success strobe, go to IDLE.
  - Any other byte: fail strobe, go to FLUSH.
- FLUSH: discard bytes until CR, then go to IDLE. No strobe on that CR.
- Strobe timing: the strobe is registered. DATA_EN=1 for exactly the one cycle after the edge that samples the deciding byte; the outputs update on that same edge.
- Success strobe:
  - STATE_R_OUT/STATE_W_OUT reflect the command type; FAIL_OUT=0.
  - ADDR_OUT = addr_sr.
  - DATA_OUT = data_sr for writes, 64'h3030_3030_3030_3030 ('0' chars) for reads.
- Fail strobe: FAIL_OUT=1, STATE_R_OUT=STATE_W_OUT=0; ADDR_OUT and DATA_OUT hold their previous values.
- Between strobes: all outputs hold their values; only DATA_EN returns to 0.
- Timeout:
  - The counter clears on every RX_VALID and in IDLE. It increments each cycle in ADDR, DATA, TERM and FLUSH.
  - When it reaches TIMEOUT_CYC: fail strobe, go to IDLE, counter clears.
  - RX_VALID in the same cycle as the timeout: the byte wins and no timeout occurs.
  - In FLUSH, a timeout returns to IDLE without a strobe.
- Back-to-back frames: a byte arriving in the cycle DATA_EN=1 is processed normally, since the FSM is already in IDLE. No bytes are dropped.

Optional Feature:
- Macro: UART_CMD_LOWERCASE_EN.
- Defined:
  - 'r'(0x72) and 'w'(0x77) are accepted as commands.
  - 'a'-'f' (0x61-0x66) are accepted as hex and stored uppercased (byte & 8'hDF), so the downstream decoder sees only uppercase.
- Undefined: lowercase bytes are treated as invalid and fail.

Test Plan:
- Send "W1A0000BEEF\r" with 1-cycle RX_VALID pulses 16 cycles apart -> one DATA_EN pulse one cycle after the CR edge; STATE_W_OUT=1, ADDR_OUT=16'h3141, DATA_OUT=64'h30303030_42454546, FAIL_OUT=0.
- Send "R7F\r" -> DATA_EN pulse with STATE_R_OUT=1, ADDR_OUT=16'h3746, DATA_OUT=64'h3030303030303030.
- Send "W1G" then "Z\r", then "R00\r" -> first frame: fail strobe at the 'G' edge (FAIL_OUT=1), no strobe for the flushed CR. Second frame: clean read strobe, ADDR_OUT=16'h3030.
- TIMEOUT_CYC=50: send "W12" then idle for 60 cycles -> fail strobe exactly 50 cycles after the last byte edge, BUSY drops to 0. A following "R12\r" succeeds.
- Assert RST_N=0 for 1 cycle after "W12345" -> all outputs 0, no strobe. A following "R05\r" gives ADDR_OUT=16'h3035.
- With UART_CMD_LOWERCASE_EN defined, send "w0a00000001\r" -> STATE_W_OUT=1, ADDR_OUT=16'h3041. Without the macro, the same bytes -> fail strobe on 'w'.
